// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// FSM state encoding, one-hot result codes and chunk-count helpers.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result codes, bit order {gt, eq, lt}
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    // Number of STEP-bit chunks in a WIDTH-bit operand
    function automatic int num_chunks(input int width, input int step);
        return width / step;
    endfunction

    // Width of the chunk index; at least one bit even for a single chunk
    function automatic int idx_width(input int width, input int step);
        int n;
        n = width / step;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// Combinational compare of one STEP-bit chunk (unsigned).
module chunk_compare #(
    parameter int STEP = 2
) (
    input  logic [STEP-1:0] i_a,
    input  logic [STEP-1:0] i_b,
    output logic            o_gt,
    output logic            o_eq,
    output logic            o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Sequential MSB-first magnitude comparator, STEP bits per cycle, with a
// start/busy/done handshake and a held one-hot gt/eq/lt result.
// Signed compares flip the operand sign bits so an unsigned compare applies.
// Optional build macro CMP_EARLY_EXIT_EN: finish as soon as a chunk differs.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N_CHUNKS = num_chunks(WIDTH, STEP);
    localparam int IDX_W    = idx_width(WIDTH, STEP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDX_W-1:0]  r_idx;
    logic              r_decided;
    logic              r_dir_gt;
    logic              r_busy;
    logic              r_done;
    logic [2:0]        r_result;

    logic [STEP-1:0]   w_chunk_a;
    logic [STEP-1:0]   w_chunk_b;
    logic              w_ch_gt;
    logic              w_ch_eq;
    logic              w_ch_lt;
    logic              w_accept;
    logic              w_dec_now;
    logic              w_gt_now;
    logic              w_run_end;
    logic [WIDTH-1:0]  w_flip;

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_flip    = {signed_mode, {(WIDTH-1){1'b0}}};

    // Decision including the chunk being compared this cycle
    assign w_dec_now = r_decided | ~w_ch_eq;
    assign w_gt_now  = r_decided ? r_dir_gt : (w_ch_gt & ~w_ch_lt);

`ifdef CMP_EARLY_EXIT_EN
    assign w_run_end = (r_idx == LAST_IDX) || w_dec_now;
`else
    assign w_run_end = (r_idx == LAST_IDX);
`endif

    // Chunk-select mux: index 0 picks the most significant chunk
    always_comb begin
        w_chunk_a = {STEP{1'b0}};
        w_chunk_b = {STEP{1'b0}};
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_chunk_a = r_a[(N_CHUNKS-1-i)*STEP +: STEP];
                w_chunk_b = r_b[(N_CHUNKS-1-i)*STEP +: STEP];
            end else begin
                w_chunk_a = w_chunk_a;
                w_chunk_b = w_chunk_b;
            end
        end
    end

    chunk_compare #(.STEP(STEP)) u_chunk_compare (
        .i_a  (w_chunk_a),
        .i_b  (w_chunk_b),
        .o_gt (w_ch_gt),
        .o_eq (w_ch_eq),
        .o_lt (w_ch_lt)
    );

    // Next-state logic for IDLE -> RUN -> DONE handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
                else       w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_run_end) w_state_nxt = DONE;
                else           w_state_nxt = RUN;
            end
            DONE: begin
                if (start) w_state_nxt = RUN;
                else       w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Operand capture, chunk walk, first-difference tracking and result load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_decided <= 1'b0;
            r_dir_gt  <= 1'b0;
            r_result  <= 3'b000;
        end else if (w_accept) begin
            r_a       <= a ^ w_flip;
            r_b       <= b ^ w_flip;
            r_idx     <= {IDX_W{1'b0}};
            r_decided <= 1'b0;
            r_dir_gt  <= 1'b0;
            r_result  <= 3'b000;
        end else if (r_state == RUN) begin
            if (!r_decided && !w_ch_eq) begin
                r_decided <= 1'b1;
                r_dir_gt  <= w_ch_gt;
            end
            if (w_run_end) begin
                r_idx    <= {IDX_W{1'b0}};
                r_result <= w_dec_now ? (w_gt_now ? CMP_GT : CMP_LT) : CMP_EQ;
            end else begin
                r_idx    <= r_idx + IDX_W'(1);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign gt   = r_result[2];
    assign eq   = r_result[1];
    assign lt   = r_result[0];

endmodule
